vin_fbwrite: RTL and testbench

Frame-buffer writer sitting directly downstream of the board-level video input. It pops 32-bit words (4 × Y8 pixels) from the input FIFO's valid/ready port and groups them into fixed-length bursts on a memory-controller write port. It also issues one write command per burst and double-buffers whole frames between two base addresses. Frame boundaries come from the synchronized vsync; short frames are zero-padded to a burst boundary and flagged.

---
 rtl/vin_fbwrite.sv | 209 ++++++++++++++++++++
 tb/tb_vin_fbwrite.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vin_fbwrite.sv
// vin_fbwrite: frame-buffer writer for the video input path.
// Groups 32-bit pixel words from the input FIFO into fixed-length write
// bursts, issues one memory write command per burst, and ping-pongs whole
// frames between two buffers. Short frames are zero-padded to a burst
// boundary and flagged; words arriving after a complete frame are dropped.
module vin_fbwrite #(
    parameter logic [29:0] FB_BASE0    = 30'h0000000,
    parameter logic [29:0] FB_BASE1    = 30'h0200000,
    parameter int          FRAME_WORDS = 480000,
    parameter int          BURST_LEN   = 16,
    parameter logic        VS_POL      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_vsync,
    input  logic [31:0] v_pixel,
    input  logic        v_valid,
    output logic        v_ready,
    output logic        wr_en,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    output logic        cmd_en,
    output logic [29:0] cmd_addr,
    output logic [5:0]  cmd_bl,
    input  logic        cmd_full,
    output logic        fb_front,
    output logic        frame_done,
    output logic        err_short,
    output logic        err_long
);

    localparam logic [2:0] S_WAIT_VS = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_PAD     = 3'd2;
    localparam logic [2:0] S_CMD     = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;

    localparam logic [5:0]  BL_LAST = 6'(BURST_LEN - 1);
    localparam logic [19:0] BL_W20  = 20'(BURST_LEN);
    localparam logic [20:0] BL_W21  = 21'(BURST_LEN);
    localparam logic [20:0] FRAME_W = 21'(FRAME_WORDS);

    logic [2:0]  r_state;
    logic        r_vs_prev;
    // r_word_cnt holds the words of all completed bursts in the frame, so it
    // is always the word offset of the burst currently being assembled.
    logic [19:0] r_word_cnt;
    logic [5:0]  r_burst_cnt;
    logic        r_abort;
    logic        r_vs_pend;
    logic [29:0] r_cmd_addr;
    logic        r_fb_front;
    logic        r_frame_done;
    logic        r_err_short;
    logic        r_err_long;

    logic        w_vs_edge;
    logic [29:0] w_base;
    logic [29:0] w_burst_addr;
    logic        w_accept;
    logic        w_pad_push;
    logic        w_cmd_issue;
    logic        w_frame_full;
    logic        w_burst_last;

    assign w_vs_edge    = (v_vsync == VS_POL) && (r_vs_prev != VS_POL);
    // The back buffer (the one not on display) is always the write target.
    assign w_base       = r_fb_front ? FB_BASE0 : FB_BASE1;
    assign w_burst_addr = w_base + {8'd0, r_word_cnt, 2'b00};
    assign w_accept     = (r_state == S_FILL) && v_valid && !wr_full;
    assign w_pad_push   = (r_state == S_PAD) && !wr_full;
    assign w_cmd_issue  = (r_state == S_CMD) && !cmd_full;
    assign w_frame_full = ({1'b0, r_word_cnt} + BL_W21) == FRAME_W;
    assign w_burst_last = (r_burst_cnt == BL_LAST);

    assign cmd_en     = w_cmd_issue;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_bl     = BL_LAST;
    assign fb_front   = r_fb_front;
    assign frame_done = r_frame_done;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;

    // Zero-latency input handshake and write-data path, selected by state.
    always_comb begin
        v_ready = 1'b0;
        wr_en   = 1'b0;
        wr_data = 32'd0;
        case (r_state)
            S_WAIT_VS, S_DISCARD: v_ready = 1'b1;
            S_FILL: begin
                v_ready = !wr_full;
                wr_en   = v_valid && !wr_full;
                wr_data = v_pixel;
            end
            S_PAD:   wr_en = !wr_full;
            default: ;
        endcase
    end

    // Frame/burst sequencing, command generation and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_WAIT_VS;
            r_vs_prev    <= !VS_POL;
            r_word_cnt   <= 20'd0;
            r_burst_cnt  <= 6'd0;
            r_abort      <= 1'b0;
            r_vs_pend    <= 1'b0;
            r_cmd_addr   <= 30'd0;
            r_fb_front   <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
        end else begin
            r_vs_prev    <= v_vsync;
            r_frame_done <= 1'b0;
            case (r_state)
                S_WAIT_VS: begin
                    if (w_vs_edge) begin
                        r_state     <= S_FILL;
                        r_word_cnt  <= 20'd0;
                        r_burst_cnt <= 6'd0;
                        r_abort     <= 1'b0;
                        r_vs_pend   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_vs_edge && r_burst_cnt == 6'd0) begin
                        // Frame restart on a burst boundary; a word accepted
                        // in this cycle is the first word of the new frame.
                        if (r_word_cnt != 20'd0)
                            r_err_short <= 1'b1;
                        r_word_cnt <= 20'd0;
                        if (w_accept && w_burst_last) begin
                            r_cmd_addr  <= w_base;
                            r_abort     <= 1'b0;
                            r_vs_pend   <= 1'b0;
                            r_burst_cnt <= 6'd0;
                            r_state     <= S_CMD;
                        end else begin
                            r_burst_cnt <= w_accept ? 6'd1 : 6'd0;
                        end
                    end else if (w_accept && w_burst_last) begin
                        // Burst complete; a coincident vsync is handled once
                        // the command is out, exactly as a pending edge.
                        r_cmd_addr <= w_burst_addr;
                        r_abort    <= 1'b0;
                        r_vs_pend  <= w_vs_edge;
                        r_state    <= S_CMD;
                    end else if (w_vs_edge) begin
                        r_burst_cnt <= r_burst_cnt + 6'(w_accept);
                        r_err_short <= 1'b1;
                        r_state     <= S_PAD;
                    end else if (w_accept) begin
                        r_burst_cnt <= r_burst_cnt + 6'd1;
                    end
                end
                S_PAD: begin
                    if (w_pad_push) begin
                        if (w_burst_last) begin
                            r_cmd_addr <= w_burst_addr;
                            r_abort    <= 1'b1;
                            r_state    <= S_CMD;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 6'd1;
                        end
                    end
                end
                S_CMD: begin
                    if (w_vs_edge)
                        r_vs_pend <= 1'b1;
                    if (w_cmd_issue) begin
                        r_burst_cnt <= 6'd0;
                        r_vs_pend   <= 1'b0;
                        r_abort     <= 1'b0;
                        r_state     <= S_FILL;
                        if (r_abort) begin
                            r_word_cnt <= 20'd0;
                        end else if (w_frame_full) begin
                            // Swap first, then honour any pending vsync.
                            r_fb_front   <= ~r_fb_front;
                            r_frame_done <= 1'b1;
                            r_word_cnt   <= 20'd0;
                            if (!(r_vs_pend || w_vs_edge))
                                r_state <= S_DISCARD;
                        end else if (r_vs_pend || w_vs_edge) begin
                            r_err_short <= 1'b1;
                            r_word_cnt  <= 20'd0;
                        end else begin
                            r_word_cnt <= r_word_cnt + BL_W20;
                        end
                    end
                end
                S_DISCARD: begin
                    if (v_valid)
                        r_err_long <= 1'b1;
                    if (w_vs_edge) begin
                        r_state     <= S_FILL;
                        r_word_cnt  <= 20'd0;
                        r_burst_cnt <= 6'd0;
                    end
                end
                default: r_state <= S_WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_vin_fbwrite.sv
// tb_vin_fbwrite: directed sequence of frames with random pixel data,
// checked against a stream-level model (words in order, zero pad to a burst
// boundary, one command per burst at base + 4*BL*k, buffer ping-pong).
module tb_vin_fbwrite;

    localparam logic [29:0] B0 = 30'h0000000;
    localparam logic [29:0] B1 = 30'h0200000;
    localparam int FW = 32;
    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_vsync = 1'b0;
    logic [31:0] v_pixel = 32'd0;
    logic        v_valid = 1'b0;
    logic        v_ready;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_full = 1'b0;
    logic        cmd_en;
    logic [29:0] cmd_addr;
    logic [5:0]  cmd_bl;
    logic        cmd_full = 1'b0;
    logic        fb_front;
    logic        frame_done;
    logic        err_short;
    logic        err_long;

    vin_fbwrite #(
        .FB_BASE0(B0), .FB_BASE1(B1), .FRAME_WORDS(FW), .BURST_LEN(BL), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .v_vsync(v_vsync), .v_pixel(v_pixel),
        .v_valid(v_valid), .v_ready(v_ready), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_bl(cmd_bl),
        .cmd_full(cmd_full), .fb_front(fb_front), .frame_done(frame_done),
        .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int prot_bad = 0;
    int done_cnt = 0;
    logic [31:0] obs_wr[$];
    logic [31:0] obs_cmd[$];
    logic [31:0] sent[$];
    logic model_front = 1'b0;

    // Monitor: records pushes/commands and flags handshake-rule violations.
    initial begin
        int  push_cnt;
        bit  prev_cmd;
        bit  prev_rst;
        logic prev_front;
        push_cnt = 0; prev_cmd = 0; prev_rst = 1; prev_front = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                push_cnt = 0;
            end else begin
                if (wr_en) begin
                    obs_wr.push_back(wr_data);
                    push_cnt++;
                    if (wr_full) prot_bad++;
                end
                if (cmd_en) begin
                    obs_cmd.push_back({2'b00, cmd_addr});
                    if (cmd_full) prot_bad++;
                    if (push_cnt != BL) prot_bad++;
                    push_cnt = 0;
                end
                if (frame_done) begin
                    done_cnt++;
                    if (!prev_cmd) prot_bad++;
                    if (fb_front == prev_front) prot_bad++;
                end else if (fb_front != prev_front && !prev_rst) begin
                    prot_bad++;
                end
            end
            prev_cmd   = cmd_en && !rst;
            prev_front = fb_front;
            prev_rst   = rst;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        v_valid = 1'b0; wr_full = 1'b0; cmd_full = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vs_pulse();
        v_valid = 1'b0;
        v_vsync = 1'b1;
        tick();
        v_vsync = 1'b0;
    endtask

    // Offer n random words; each is held until the handshake takes it.
    task automatic send_words(input int n, input bit rnd_full, input int cf_hold);
        int cyc;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            bit taken;
            int waited;
            w = $urandom;
            taken = 0;
            waited = 0;
            v_valid = 1'b1;
            v_pixel = w;
            while (!taken && waited < 300) begin
                wr_full  = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
                cmd_full = (cyc < cf_hold);
                @(negedge clk);
                taken = v_ready;
                tick();
                cyc++;
                waited++;
            end
            if (!taken) begin
                n_cmp++;
                n_bad++;
                $error("FAIL send_timeout: observed no v_ready after %0d cycles expected handshake", waited);
            end
            sent.push_back(w);
        end
        v_valid = 1'b0; wr_full = 1'b0; cmd_full = 1'b0;
    endtask

    // Expected streams: sent words then zeros up to a burst boundary, and
    // one command per burst at consecutive burst offsets from base.
    task automatic compare_streams(input string tag, input logic [29:0] base);
        int nb;
        nb = (sent.size() + BL - 1) / BL;
        check({tag, "_nwr"}, obs_wr.size(), nb * BL);
        for (int i = 0; i < nb * BL && i < obs_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), obs_wr[i], (i < sent.size()) ? sent[i] : 32'd0);
        check({tag, "_ncmd"}, obs_cmd.size(), nb);
        for (int k = 0; k < nb && k < obs_cmd.size(); k++)
            check($sformatf("%s_cmd%0d", tag, k), obs_cmd[k], {2'b00, base} + 32'(4 * BL * k));
    endtask

    task automatic run_frame(input string tag, input bit do_vs, input bit rnd_full, input int cf_hold);
        logic [29:0] base;
        int d0;
        base = model_front ? B0 : B1;
        d0 = done_cnt;
        obs_wr.delete(); obs_cmd.delete(); sent.delete();
        if (do_vs) vs_pulse();
        send_words(FW, rnd_full, cf_hold);
        idle(40);
        compare_streams(tag, base);
        model_front = !model_front;
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_front"}, {31'd0, fb_front}, {31'd0, model_front});
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_v_ready"}, {31'd0, v_ready}, 1);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_cmd_en"}, {31'd0, cmd_en}, 0);
        check({tag, "_cmd_addr"}, {2'b00, cmd_addr}, 0);
        check({tag, "_cmd_bl"}, {26'd0, cmd_bl}, BL - 1);
        check({tag, "_fb_front"}, {31'd0, fb_front}, 0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
        check({tag, "_err_short"}, {31'd0, err_short}, 0);
        check({tag, "_err_long"}, {31'd0, err_long}, 0);
    endtask

    // Global bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion expected $finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // Power-on reset with junk on the input.
        rst = 1'b1;
        v_valid = 1'b1;
        v_pixel = $urandom;
        tick(); tick(); tick();
        check_reset_outputs("por");
        tick();
        rst = 1'b0;

        // Waiting for the first vsync: input words are popped and dropped.
        obs_wr.delete();
        for (int i = 0; i < 4; i++) begin
            v_valid = 1'b1;
            v_pixel = $urandom;
            tick();
        end
        idle(2);
        check("wait_vs_nowr", obs_wr.size(), 0);

        // Two complete frames: buffer 1 then buffer 0.
        run_frame("f1", 1'b1, 1'b0, 0);
        check("f1_err_short", {31'd0, err_short}, 0);
        check("f1_err_long", {31'd0, err_long}, 0);
        run_frame("f2", 1'b1, 1'b0, 0);

        // Short frame: 11 words then vsync -> padded to 16, flagged, no swap.
        obs_wr.delete(); obs_cmd.delete(); sent.delete();
        d0 = done_cnt;
        vs_pulse();
        send_words(11, 1'b0, 0);
        vs_pulse();
        idle(40);
        compare_streams("short", model_front ? B0 : B1);
        check("short_err", {31'd0, err_short}, 1);
        check("short_front", {31'd0, fb_front}, {31'd0, model_front});
        check("short_done", done_cnt - d0, 0);
        // The terminating vsync already started the rewrite of the same buffer.
        run_frame("restart", 1'b0, 1'b0, 0);

        // Backpressure on both write data and command ports.
        run_frame("stall", 1'b1, 1'b1, 40);

        // Extra words after a completed frame are dropped and flagged.
        check("extra_err_long_pre", {31'd0, err_long}, 0);
        obs_wr.delete(); sent.delete();
        send_words(3, 1'b0, 0);
        idle(4);
        check("extra_nowr", obs_wr.size(), 0);
        check("extra_err_long", {31'd0, err_long}, 1);
        check("extra_err_short_sticky", {31'd0, err_short}, 1);

        run_frame("f5", 1'b1, 1'b0, 0);

        // Reset in the middle of a burst.
        vs_pulse();
        send_words(5, 1'b0, 0);
        rst = 1'b1;
        v_valid = 1'b1;
        v_pixel = $urandom;
        tick();
        check_reset_outputs("midrst");
        model_front = 1'b0;
        tick();
        rst = 1'b0;
        obs_wr.delete(); obs_cmd.delete();
        for (int i = 0; i < 4; i++) begin
            v_valid = 1'b1;
            v_pixel = $urandom;
            tick();
        end
        idle(2);
        check("midrst_nowr", obs_wr.size(), 0);
        check("midrst_nocmd", obs_cmd.size(), 0);
        run_frame("after_rst", 1'b1, 1'b0, 0);

        check("protocol", prot_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
